// File: rtl/miner_pkg.sv
// Shared widths, FSM state and record types for the miner work dispatcher and the miner core.
package miner_pkg;

    localparam int HDR_W   = 512;
    localparam int HASH_W  = 256;
    localparam int NONCE_W = 32;

    // SHA-256 initial hash value H0..H7; the miner core seeds its first compression with this.
    localparam logic [255:0] SHA256_H0 =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

    typedef struct packed {
        logic [HDR_W-1:0]   header;
        logic [HASH_W-1:0]  target;
        logic [NONCE_W-1:0] nonce_end;
    } job_t;

    typedef struct packed {
        logic               vld;
        logic               hit;
        logic [NONCE_W-1:0] nonce;
        logic [HASH_W-1:0]  hash;
    } cmp_t;

endpackage

// File: rtl/nonce_fifo.sv
// Synchronous FIFO holding the nonces currently inside the miner, oldest at the head.
module nonce_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             do_push, do_pop;

    // A pop frees the slot in the same cycle, so a full FIFO still takes a push alongside a pop.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/miner_work_dispatcher.sv
// Issues one nonce-stamped header per cycle into the miner, pairs returning hashes with their
// nonces in order, and presents hashes at or below the job target on a one-entry result slot.
module miner_work_dispatcher
    import miner_pkg::*;
#(
    parameter int NONCE_LSB  = 384,
    parameter int FIFO_DEPTH = 64,
    parameter int FIFO_AW    = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               job_valid,
    output logic               job_ready,
    input  logic [HDR_W-1:0]   job_header,
    input  logic [HASH_W-1:0]  job_target,
    input  logic [NONCE_W-1:0] job_nonce_start,
    input  logic [NONCE_W-1:0] job_nonce_end,
    input  logic               abort,
    output logic               miner_input_valid,
    output logic [HDR_W-1:0]   miner_block_header,
    input  logic               miner_output_valid,
    input  logic [HASH_W-1:0]  miner_hash_result,
    output logic               found_valid,
    input  logic               found_ready,
    output logic [NONCE_W-1:0] found_nonce,
    output logic [HASH_W-1:0]  found_hash,
    output logic               found_drop,
    output logic               busy,
    output logic               done,
    output logic               err_orphan
);

    state_t             state;
    job_t               job;
    logic [NONCE_W-1:0] cur;
    logic               discard;
    cmp_t               cmp;

    logic               fifo_full, fifo_empty;
    logic [NONCE_W-1:0] head_nonce;
    logic               issue, res_pop, res_cmp;

    assign job_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    // Abort takes effect in the cycle it is raised, both for issue and for result comparison.
    assign issue    = (state == ISSUE) && !abort && !fifo_full;
    assign res_pop  = miner_output_valid && !fifo_empty;
    assign res_cmp  = res_pop && !discard && !(abort && state != IDLE);

    assign miner_input_valid = issue;

    always_comb begin
        miner_block_header = job.header;
        miner_block_header[NONCE_LSB +: NONCE_W] = cur;
    end

    nonce_fifo #(
        .WIDTH (NONCE_W),
        .DEPTH (FIFO_DEPTH),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (issue),
        .push_data (cur),
        .pop       (res_pop),
        .pop_data  (head_nonce),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            job     <= '0;
            cur     <= '0;
            discard <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (job_valid) begin
                        job   <= '{header: job_header, target: job_target, nonce_end: job_nonce_end};
                        cur   <= job_nonce_start;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (abort) begin
                        discard <= 1'b1;
                        state   <= DRAIN;
                    end else if (!fifo_full) begin
                        if (cur == job.nonce_end) state <= DRAIN;
                        else                      cur   <= cur + 32'd1;
                    end
                end
                DRAIN: begin
                    if (abort) discard <= 1'b1;
                    // Holding off while a compare is registered keeps done from beating its hit.
                    if (fifo_empty && !cmp.vld) begin
                        done    <= 1'b1;
                        discard <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmp        <= '0;
            err_orphan <= 1'b0;
        end else begin
            cmp.vld   <= res_pop;
            cmp.hit   <= res_cmp && (miner_hash_result <= job.target);
            cmp.nonce <= head_nonce;
            cmp.hash  <= miner_hash_result;
            if (miner_output_valid && fifo_empty) err_orphan <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            found_valid <= 1'b0;
            found_nonce <= '0;
            found_hash  <= '0;
            found_drop  <= 1'b0;
        end else begin
            found_drop <= 1'b0;
            if (found_valid && found_ready) found_valid <= 1'b0;
            if (cmp.hit) begin
                if (!found_valid || found_ready) begin
                    found_valid <= 1'b1;
                    found_nonce <= cmp.nonce;
                    found_hash  <= cmp.hash;
                end else begin
                    found_drop <= 1'b1;
                end
            end
        end
    end

endmodule
